// File: rtl/rv32m_muldiv_unit.sv
// RV32M multiply/divide unit: single-cycle-issue multiplier and a
// 32-iteration restoring divider with sign fix-up, flush and async reset.
module rv32m_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [2:0]       i_funct3,
    input  logic [WIDTH-1:0] i_rs1_data,
    input  logic [WIDTH-1:0] i_rs2_data,
    input  logic             i_flush,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result
);

    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [5:0]       cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic             nq_q, nq_d;
    logic             nr_q, nr_d;

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic               ae, be;
    logic               sa, sb;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic               ovf;

    always_comb begin
        // MULH/MULHSU treat rs1 as signed; only MULH treats rs2 as signed
        ae = (op_q == 2'b01 || op_q == 2'b10) && a_q[WIDTH-1];
        be = (op_q == 2'b01) && b_q[WIDTH-1];
        prod = {{WIDTH{ae}}, a_q} * {{WIDTH{be}}, b_q};
        shifted = {rem_q, a_q[WIDTH-1]};
        diff = shifted - {1'b0, b_q};
        sa = !i_funct3[0] && i_rs1_data[WIDTH-1];
        sb = !i_funct3[0] && i_rs2_data[WIDTH-1];
        mag_a = sa ? (~i_rs1_data + 1'b1) : i_rs1_data;
        mag_b = sb ? (~i_rs2_data + 1'b1) : i_rs2_data;
        ovf = !i_funct3[0]
            && i_rs1_data == {1'b1, {(WIDTH-1){1'b0}}}
            && i_rs2_data == {WIDTH{1'b1}};
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        rem_d   = rem_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        nq_d    = nq_q;
        nr_d    = nr_q;
        if (i_flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    state_d = IDLE;
                    if (i_start) begin
                        op_d = i_funct3[1:0];
                        if (!i_funct3[2]) begin
                            a_d     = i_rs1_data;
                            b_d     = i_rs2_data;
                            state_d = MUL;
                        end else if (i_rs2_data == '0) begin
                            res_d   = i_funct3[1] ? i_rs1_data : '1;
                            state_d = DONE;
                        end else if (ovf) begin
                            res_d   = i_funct3[1] ? '0 : i_rs1_data;
                            state_d = DONE;
                        end else begin
                            a_d     = mag_a;
                            b_d     = mag_b;
                            rem_d   = '0;
                            cnt_d   = '0;
                            nq_d    = sa ^ sb;
                            nr_d    = sa;
                            state_d = DIV;
                        end
                    end
                end
                MUL: begin
                    res_d   = (op_q == 2'b00) ? prod[WIDTH-1:0]
                                              : prod[2*WIDTH-1:WIDTH];
                    state_d = DONE;
                end
                DIV: begin
                    // quotient bits shift into a_q as dividend bits shift out
                    if (!diff[WIDTH]) begin
                        rem_d = diff[WIDTH-1:0];
                        a_d   = {a_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = shifted[WIDTH-1:0];
                        a_d   = {a_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'd31) state_d = FIX;
                end
                FIX: begin
                    if (op_q[1]) res_d = nr_q ? (~rem_q + 1'b1) : rem_q;
                    else         res_d = nq_q ? (~a_q + 1'b1) : a_q;
                    state_d = DONE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            nq_q    <= 1'b0;
            nr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            nq_q    <= nq_d;
            nr_q    <= nr_d;
        end
    end

    assign o_busy   = (state_q == MUL) || (state_q == DIV) || (state_q == FIX);
    assign o_done   = (state_q == DONE);
    assign o_result = res_q;

endmodule

// File: tb/tb_rv32m_muldiv_unit.sv
// Scoreboard bench for rv32m_muldiv_unit: directed vectors, a monitor
// checking result and completion cycle of every o_done pulse.
module tb_rv32m_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_start = 1'b0;
    logic [2:0]  i_funct3 = '0;
    logic [31:0] i_rs1_data = '0;
    logic [31:0] i_rs2_data = '0;
    logic        i_flush = 1'b0;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_result;

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   ncmp = 0;
    int   nerr = 0;

    rv32m_muldiv_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_start    (i_start),
        .i_funct3   (i_funct3),
        .i_rs1_data (i_rs1_data),
        .i_rs2_data (i_rs2_data),
        .i_flush    (i_flush),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_result   (o_result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // monitor: every o_done must match the oldest expected completion
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (o_done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", o_result, 32'hx);
                end else begin
                    e = sb.pop_front();
                    chk("result", o_result, e.res);
                    chk("done_cycle", cyc, e.cyc);
                end
            end
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                e = sb.pop_front();
                chk("missing_done", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // call at a negedge; returns at the negedge after the accepting edge
    task automatic issue(input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp,
                         input int lat, input bit push);
        i_start    = 1'b1;
        i_funct3   = f;
        i_rs1_data = a;
        i_rs2_data = b;
        if (push) sb.push_back('{res: exp, cyc: cyc + 1 + lat});
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic finish_op(input string nm, input int exp_busy,
                             input bit poke);
        int  nbusy = 0;
        bit  seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            i_start = 1'b0;
            if (o_done) begin
                seen = 1;
            end else begin
                if (o_busy) nbusy++;
                if (poke && o_busy && (i % 4 == 1)) begin
                    i_start    = 1'b1;
                    i_funct3   = 3'b000;
                    i_rs1_data = 32'd9;
                    i_rs2_data = 32'd9;
                end
                @(negedge clk);
            end
        end
        i_start = 1'b0;
        chk({nm, "_busy_cycles"}, 32'(nbusy), 32'(exp_busy));
        if (!seen) chk({nm, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_busy", {31'd0, o_busy}, 32'd0);
        chk("reset_done", {31'd0, o_done}, 32'd0);
        chk("reset_result", o_result, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        issue(3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 1, 1);
        finish_op("mul", 1, 0);
        issue(3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 1, 1);
        finish_op("mulh", 1, 0);
        issue(3'b011, 32'h80000000, 32'h80000000, 32'h40000000, 1, 1);
        finish_op("mulhu", 1, 0);
        issue(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1);
        finish_op("mulhsu", 1, 0);

        issue(3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, 1);
        finish_op("div", 33, 1);
        issue(3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33, 1);
        finish_op("rem", 33, 1);

        issue(3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, 0, 1);
        finish_op("divu0", 0, 0);
        issue(3'b111, 32'd5, 32'd0, 32'd5, 0, 1);
        finish_op("remu0", 0, 0);
        issue(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 1);
        finish_op("divovf", 0, 0);

        // flush mid-divide with a simultaneous start that must be dropped
        @(negedge clk);
        issue(3'b101, 32'd100, 32'd7, 32'd0, 33, 0);
        repeat (10) @(negedge clk);
        i_flush    = 1'b1;
        i_start    = 1'b1;
        i_funct3   = 3'b000;
        i_rs1_data = 32'd5;
        i_rs2_data = 32'd5;
        @(negedge clk);
        i_flush = 1'b0;
        i_start = 1'b0;
        chk("flush_busy", {31'd0, o_busy}, 32'd0);
        chk("flush_done", {31'd0, o_done}, 32'd0);
        chk("flush_result", o_result, 32'h80000000);
        repeat (3) @(negedge clk);
        chk("flush_idle_busy", {31'd0, o_busy}, 32'd0);
        issue(3'b000, 32'h12345678, 32'h10, 32'h23456780, 1, 1);
        finish_op("mul_after_flush", 1, 0);

        // asynchronous reset in the middle of a divide
        @(negedge clk);
        issue(3'b100, 32'd1000, 32'd3, 32'd0, 33, 0);
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_busy", {31'd0, o_busy}, 32'd0);
        chk("arst_done", {31'd0, o_done}, 32'd0);
        chk("arst_result", o_result, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        issue(3'b111, 32'd100, 32'd7, 32'd2, 33, 1);
        finish_op("remu", 33, 0);
        issue(3'b000, 32'd3, 32'd4, 32'd12, 1, 1);
        finish_op("mul_b2b", 1, 0);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/rv32m_muldiv_unit.md
RV32M_MULDIV_UNIT -- requirements
Module: rv32m_muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and result width; only 32 is supported.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port i_start, input, 1: EX stage requests an M-extension operation.
REQ-005 SHALL have port i_funct3, input, 3: operation select. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have port i_rs1_data, input, 32: operand A (dividend / multiplicand).
REQ-007 SHALL have port i_rs2_data, input, 32: operand B (divisor / multiplier).
REQ-008 SHALL have port i_flush, input, 1: synchronous abort from a taken branch or jump.
REQ-009 SHALL have port o_busy, output, 1: operation in progress; the EX stage holds the pipeline while it is high.
REQ-010 SHALL have port o_done, output, 1: one-cycle pulse; o_result is valid for the EX/MEM register.
REQ-011 SHALL have port o_result, output, 32: result of the last completed operation.

Function
REQ-012 SHALL implement FSM states IDLE, MUL, DIV, FIX, DONE.
REQ-013 SHALL accept i_start only in IDLE or DONE, and ignore it in MUL, DIV and FIX.
REQ-014 SHALL latch operands and i_funct3 at the edge where a start is accepted (edge k).
REQ-015 SHALL, for MUL*, go to MUL at edge k, register the selected product word into o_result and go to DONE at edge k+1, giving o_done high in the cycle after edge k+1.
REQ-016 SHALL compute the 64-bit product with operand signedness set by the op:
- MUL: low 32 bits.
- MULH: high 32 bits, signed x signed.
- MULHSU: high 32 bits, signed rs1 x unsigned rs2.
- MULHU: high 32 bits, unsigned x unsigned.
REQ-017 SHALL, for normal DIV*/REM*, go to DIV at edge k and run a restoring divider on operand magnitudes.
REQ-018 SHALL perform one quotient bit per edge over edges k+1..k+32, using a 6-bit iteration counter that starts at 0 and leaves DIV when the counter equals 31.
REQ-019 SHALL apply sign correction in FIX and enter DONE at edge k+33, giving o_done high in the cycle after edge k+33.
REQ-020 SHALL apply signed-op sign rules: quotient negative iff operand signs differ; remainder takes the dividend's sign.
REQ-021 SHALL bypass the divider and enter DONE directly at edge k for these special cases:
- Divide by zero: DIV/DIVU return 0xFFFFFFFF; REM/REMU return rs1.
- Signed overflow (DIV of 0x80000000 by 0xFFFFFFFF): returns 0x80000000; REM returns 0.
REQ-022 SHALL assert o_busy in MUL, DIV and FIX only, and assert o_done in DONE only.
REQ-023 SHALL leave DONE after one cycle: to IDLE without i_start, or to MUL/DIV/DONE per the new operation when i_start is high (back-to-back).
REQ-024 SHALL, on i_flush in any state, go to IDLE at the next edge, deassert o_busy and o_done, and keep o_result unchanged.
REQ-025 SHALL give i_flush priority over a simultaneous i_start, which is dropped.
REQ-026 SHALL hold o_result stable from DONE until the next completed operation.

Reset
REQ-027 SHALL, while rst=0, immediately force the state to IDLE and reset o_busy=0, o_done=0, o_result=0, the counter and all operand/working registers to 0, independent of clk.
REQ-028 SHALL abandon any in-flight operation on a reset mid-operation, produce no o_done for it, and accept a new start at the first edge after rst returns high.

Verification
REQ-029 SHALL pass: MUL 7 x 0xFFFFFFFD (-3) -> o_result 0xFFFFFFEB, o_done high exactly in the cycle after edge k+1, o_busy high for one cycle.
REQ-030 SHALL pass: MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU of the same operands -> 0x40000000; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-031 SHALL pass: DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM of the same operands -> 0xFFFFFFFF; o_done in the cycle after edge k+33 with o_busy high for 33 cycles; i_start pulses during busy are ignored.
REQ-032 SHALL pass: DIVU 5 / 0 -> 0xFFFFFFFF; REMU 5 / 0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; each with o_done in the cycle after edge k.
REQ-033 SHALL pass: DIVU 100 / 7 started, i_flush at iteration 10 -> IDLE next edge, no o_done, o_result keeps its previous value; a following MUL completes normally.
REQ-034 SHALL pass: rst=0 driven mid-DIV between edges -> o_busy and o_result read 0 immediately; after release, back-to-back REMU 100 / 7 -> 2, then MUL 3 x 4 -> 12.
